// File: rtl/ext_mem_pkg.sv
// Shared definitions for the external-memory responder: state codes,
// transfer direction, error read pattern and byte-to-word address helper.
package ext_mem_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int DATA_W     = 32;
  localparam int BYTE_ADDR_W = 27;
  localparam int WORD_IDX_W  = 25;

  localparam logic [DATA_W-1:0] ERR_READ_PATTERN = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    RD_ZERO = 2'd0,
    RD_RAM  = 2'd1,
    RD_ERR  = 2'd2
  } rd_src_t;

  function automatic logic [WORD_IDX_W-1:0] byte_to_word(input logic [BYTE_ADDR_W-1:0] byte_addr);
    return byte_addr[BYTE_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/ext_mem_ram_sp.sv
// Single-port synchronous word RAM, one-cycle read latency, write-first
// when a read and a write hit the port in the same cycle.
module ext_mem_ram_sp #(
  parameter int DEPTH  = 65536,
  parameter int AW     = $clog2(DEPTH),
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= we ? wdata : mem[addr];
  end

endmodule

// File: rtl/ext_mem_responder.sv
// Responder end of the external-memory request interface over on-chip RAM.
// Optional bounds checking is enabled by defining EXT_MEM_BOUNDS_CHECK_EN.
module ext_mem_responder
  import ext_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 65536,
  parameter int BLOCK_WORDS = 8,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        reqBlock_i,
  input  logic        rw_i,
  input  logic        clear_i,
  input  logic [31:0] data_i,
  input  logic [26:0] add_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        done_o,
  output logic        valid_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BW = $clog2(BLOCK_WORDS);
  localparam int CW = $clog2(WAIT_CYCLES + 1);

  logic [2:0]            state;
  logic [CW-1:0]         wait_cnt;
  logic [BW:0]           beat_cnt;
  logic [BW:0]           beat_last;
  logic                  rw;
  logic [WORD_IDX_W-1:0] addr;
  logic [WORD_IDX_W-1:0] word_idx;
  logic [WORD_IDX_W-1:0] start_addr;
  logic                  start_oob;
  logic                  oob;
  rd_src_t               rd_src;
  logic [DATA_W-1:0]     ram_rdata;
  logic                  accept;
  logic                  last_wait;
  logic                  last_beat;
  logic                  ram_re;
  logic                  ram_we;

  assign word_idx   = byte_to_word(add_i);
  assign start_addr = reqBlock_i ? (word_idx & ~WORD_IDX_W'(BLOCK_WORDS - 1)) : word_idx;
  assign accept     = (state == ST_IDLE) && req_i && !clear_i;
  assign last_wait  = (wait_cnt == CW'(WAIT_CYCLES - 1));
  assign last_beat  = (beat_cnt == beat_last);

  // Reads run one cycle ahead of the beat so data_o comes straight off the RAM register
  assign ram_re = !clear_i && (rw == RW_READ) &&
                  (((state == ST_WAIT) && last_wait) || ((state == ST_READ) && !last_beat));
  assign ram_we = !clear_i && (state == ST_WRITE) && !oob;

`ifdef EXT_MEM_BOUNDS_CHECK_EN
  assign start_oob = ({1'b0, word_idx} >= (WORD_IDX_W + 1)'(DEPTH_WORDS));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      oob   <= 1'b0;
      err_o <= 1'b0;
    end else if (accept) begin
      oob   <= start_oob;
      err_o <= err_o | start_oob;
    end
  end
`else
  assign start_oob = 1'b0;
  assign oob       = start_oob;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      beat_cnt  <= '0;
      beat_last <= '0;
      rw        <= RW_READ;
      rd_src    <= RD_ZERO;
    end else begin
      if (ram_re) rd_src <= oob ? RD_ERR : RD_RAM;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_WAIT;
            wait_cnt  <= '0;
            beat_cnt  <= '0;
            rw        <= rw_i;
            beat_last <= reqBlock_i ? (BW + 1)'(BLOCK_WORDS - 1) : '0;
          end
        end
        ST_WAIT: begin
          if (clear_i)        state <= ST_IDLE;
          else if (last_wait) state <= (rw == RW_WRITE) ? ST_WRITE : ST_READ;
          else                wait_cnt <= wait_cnt + 1'b1;
        end
        ST_READ, ST_WRITE: begin
          if (clear_i)        state <= ST_IDLE;
          else if (last_beat) state <= ST_DONE;
          else                beat_cnt <= beat_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Word address: loaded at acceptance, advanced per read issue or write beat
  always_ff @(posedge clock_i) begin
    if (accept)                             addr <= start_addr;
    else if (ram_re || (state == ST_WRITE)) addr <= addr + 1'b1;
  end

  ext_mem_ram_sp #(
    .DEPTH  (DEPTH_WORDS),
    .AW     (AW),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clock_i),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr[AW-1:0]),
    .wdata (data_i),
    .rdata (ram_rdata)
  );

  assign ready_o = (state == ST_IDLE);
  assign done_o  = (state == ST_DONE);
  assign valid_o = (state == ST_READ) || (state == ST_WRITE);

  always_comb begin
    data_o = '0;
    case (rd_src)
      RD_RAM:  data_o = ram_rdata;
      RD_ERR:  data_o = ERR_READ_PATTERN;
      default: data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed scoreboard bench for ext_mem_responder: handshake timing,
// single/block transfers, clear, ignored requests, async reset, address range.
module tb_ext_mem_responder;

  localparam int DEPTH = 1024;
  localparam int BLK   = 8;
  localparam int W     = 3;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        req_i;
  logic        reqBlock_i;
  logic        rw_i;
  logic        clear_i;
  logic [31:0] data_i;
  logic [26:0] add_i;
  logic [31:0] data_o;
  logic        ready_o;
  logic        done_o;
  logic        valid_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [int];
  logic [31:0] q_exp [$];
  logic [31:0] wbuf  [BLK];

  ext_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BLOCK_WORDS (BLK),
    .WAIT_CYCLES (W)
  ) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .req_i      (req_i),
    .reqBlock_i (reqBlock_i),
    .rw_i       (rw_i),
    .clear_i    (clear_i),
    .data_i     (data_i),
    .add_i      (add_i),
    .data_o     (data_o),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .valid_o    (valid_o),
    .err_o      (err_o)
  );

  always #5 clock_i = ~clock_i;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_oob(input int w);
`ifdef EXT_MEM_BOUNDS_CHECK_EN
    return w >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int map_word(input int w);
    return w % DEPTH;
  endfunction

  // One transaction, checked cycle by cycle; cycle 0 is the accepting edge.
  task automatic run(input bit rw, input bit blk, input logic [26:0] a,
                     input int clr_cyc, input bit busy_req);
    int n;
    int start;
    int last;
    int dones;
    bit oob;
    bit exp_rdy;
    bit exp_vld;
    bit exp_done;
    logic [31:0] e;
    n     = blk ? BLK : 1;
    start = int'(a[26:2]);
    if (blk) start = start & ~(BLK - 1);
    oob   = is_oob(start);
    last  = (clr_cyc >= 0) ? clr_cyc + 1 : W + n + 2;
    dones = 0;
    if (!rw) begin
      for (int k = 0; k < n; k++) begin
        if (oob) q_exp.push_back(32'hDEADBEEF);
        else     q_exp.push_back(model.exists(map_word(start + k)) ? model[map_word(start + k)] : 32'h0);
      end
    end
    req_i = 1'b1; rw_i = rw; reqBlock_i = blk; add_i = a; data_i = wbuf[0]; clear_i = 1'b0;
    @(posedge clock_i); #1;
    req_i = 1'b0;
    for (int c = 1; c <= last; c++) begin
      if (busy_req) begin
        req_i      = (c >= 2 && c <= W + n);
        rw_i       = ~rw;
        reqBlock_i = ~blk;
        add_i      = 27'($urandom);
      end
      if (c == clr_cyc) clear_i = 1'b1;
      if (rw && c >= W + 1 && c <= W + n) data_i = wbuf[c - W - 1];
      @(negedge clock_i);
      exp_rdy  = (c == last);
      exp_vld  = !exp_rdy && (c >= W + 1) && (c <= W + n);
      exp_done = !exp_rdy && (c == W + n + 1);
      chk($sformatf("ready_c%0d", c), {31'b0, ready_o}, {31'b0, exp_rdy});
      chk($sformatf("valid_c%0d", c), {31'b0, valid_o}, {31'b0, exp_vld});
      chk($sformatf("done_c%0d", c), {31'b0, done_o}, {31'b0, exp_done});
      if (done_o) dones++;
      if (exp_vld && !rw && q_exp.size() > 0) begin
        e = q_exp.pop_front();
        chk($sformatf("rdata_beat%0d", c - W - 1), data_o, e);
      end
      if (exp_vld && rw && c != clr_cyc && !oob) model[map_word(start + c - W - 1)] = wbuf[c - W - 1];
      @(posedge clock_i); #1;
      clear_i = 1'b0;
      req_i   = 1'b0;
    end
    chk("done_count", dones, (clr_cyc < 0) ? 1 : 0);
    q_exp.delete();
  endtask

  initial begin
    reset_i = 1'b1; req_i = 1'b0; reqBlock_i = 1'b0; rw_i = 1'b0; clear_i = 1'b0;
    data_i = '0; add_i = '0;
    #12;
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    @(negedge clock_i);
    reset_i = 1'b0;
    @(posedge clock_i); #1;

    // single write then read
    wbuf[0] = 32'hCAFE0001;
    run(1'b1, 1'b0, 27'h100, -1, 1'b0);
    run(1'b0, 1'b0, 27'h100, -1, 1'b0);

    // block write at unaligned 0x24, block read at 0x20
    for (int k = 0; k < BLK; k++) wbuf[k] = 32'h10 + k;
    run(1'b1, 1'b1, 27'h24, -1, 1'b0);
    run(1'b0, 1'b1, 27'h20, -1, 1'b0);
    chk("hold_after_read", data_o, 32'h17);

    // prefill block 0x40, overwrite with clear on the third beat, read back
    for (int k = 0; k < BLK; k++) wbuf[k] = 32'hAAAA0000 + k;
    run(1'b1, 1'b1, 27'h40, -1, 1'b0);
    for (int k = 0; k < BLK; k++) wbuf[k] = 32'h55550000 + k;
    run(1'b1, 1'b1, 27'h40, W + 3, 1'b0);
    run(1'b0, 1'b1, 27'h40, -1, 1'b0);

    // requests while busy are ignored
    run(1'b0, 1'b1, 27'h20, -1, 1'b1);

    // clear wins over a request in IDLE
    req_i = 1'b1; clear_i = 1'b1; rw_i = 1'b0; reqBlock_i = 1'b0; add_i = 27'h100;
    @(posedge clock_i); #1;
    req_i = 1'b0; clear_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock_i);
      chk($sformatf("clrreq_ready_c%0d", c), {31'b0, ready_o}, 32'd1);
      chk($sformatf("clrreq_valid_c%0d", c), {31'b0, valid_o}, 32'd0);
    end
    @(posedge clock_i); #1;

    // async reset mid-read
    req_i = 1'b1; rw_i = 1'b0; reqBlock_i = 1'b1; add_i = 27'h20;
    @(posedge clock_i); #1;
    req_i = 1'b0;
    repeat (W + 1) @(posedge clock_i);
    #2;
    chk("pre_rst_valid", {31'b0, valid_o}, 32'd1);
    chk("pre_rst_data", data_o, 32'h11);
    reset_i = 1'b1;
    #1;
    chk("arst_ready", {31'b0, ready_o}, 32'd1);
    chk("arst_valid", {31'b0, valid_o}, 32'd0);
    chk("arst_done", {31'b0, done_o}, 32'd0);
    chk("arst_data", data_o, 32'd0);
    @(negedge clock_i);
    reset_i = 1'b0;
    @(posedge clock_i); #1;
    run(1'b0, 1'b1, 27'h20, -1, 1'b0);

    // address range: word 1024 is out of range or aliases to word 0
    wbuf[0] = 32'h11112222;
    run(1'b1, 1'b0, 27'h0, -1, 1'b0);
    chk("err_before", {31'b0, err_o}, 32'd0);
    run(1'b0, 1'b0, 27'h1000, -1, 1'b0);
`ifdef EXT_MEM_BOUNDS_CHECK_EN
    chk("err_set", {31'b0, err_o}, 32'd1);
`else
    chk("err_set", {31'b0, err_o}, 32'd0);
`endif
    wbuf[0] = 32'h00000099;
    run(1'b1, 1'b0, 27'h1000, -1, 1'b0);
    run(1'b0, 1'b0, 27'h0, -1, 1'b0);
`ifdef EXT_MEM_BOUNDS_CHECK_EN
    chk("err_sticky", {31'b0, err_o}, 32'd1);
`else
    chk("err_sticky", {31'b0, err_o}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ext_mem_responder.md
Name: ext_mem_responder

Overview:
- Target end of the external-memory request interface: the block that receives req/reqBlock/rw/clear/add/data and returns data/ready/done/valid.
- Implements the responder protocol over an on-chip synchronous word RAM.
- Used as the SDRAM stand-in for simulation and small FPGA builds, so the system controller runs unchanged without the SDRAM PHY.
- Supports single-word and fixed-length block transfers, with programmable wait states that model SDRAM latency.

Parameters:
- DEPTH_WORDS, 65536, RAM depth in 32-bit words; power of two.
- BLOCK_WORDS, 8, beats per block transfer; power of two, 2..64.
- WAIT_CYCLES, 3, idle cycles between request acceptance and first beat; at least 1.

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- req_i  in  1  request strobe; sampled only while ready_o=1
- reqBlock_i  in  1  1=block transfer (BLOCK_WORDS beats), 0=single word
- rw_i  in  1  1=write, 0=read
- clear_i  in  1  abort; returns block to idle
- data_i  in  32  write data
- add_i  in  27  byte address; word index = add_i[26:2]
- data_o  out  32  read data, qualified by valid_o on reads
- ready_o  out  1  1=idle and able to accept a request
- done_o  out  1  one-cycle pulse at transaction end
- valid_o  out  1  beat strobe (read: data_o valid; write: data_i consumed)
- err_o  out  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE.
  - ready_o=1; done_o=0; valid_o=0; data_o=0; err_o=0.
  - Counters 0. RAM contents are not reset.
- States: IDLE, WAIT, READ, WRITE, DONE.
- IDLE:
  - ready_o=1.
  - If req_i=1 and clear_i=0: latch rw_i, reqBlock_i and the start word address, then go to WAIT.
  - Beat count N = BLOCK_WORDS for a block, 1 for a single word.
  - Block start address is aligned down: add_i[26:2] with its low log2(BLOCK_WORDS) bits cleared.
  - Single-word transfers use the word index unmodified.
- Timing, with cycle 0 as the accepting edge:
  - ready_o=0 from cycle 1.
  - WAIT lasts WAIT_CYCLES cycles.
  - Beats occupy cycles W+1 .. W+N.
  - done_o=1 in cycle W+N+1 (state DONE).
  - ready_o=1 again in cycle W+N+2.
- READ:
  - The RAM read for beat k is issued one cycle early (the last WAIT cycle covers beat 0), so data_o is registered.
  - valid_o=1 for N consecutive cycles with ascending addresses. No gaps and no backpressure.
- WRITE:
  - In each beat cycle, data_i is written to the current address and valid_o=1.
  - The initiator holds word k stable until the cycle valid_o is high for k, then presents word k+1 on the next cycle.
- Block addresses increment within the aligned block. The start is already aligned, so there is no intra-block wrap.
- Outside READ, data_o holds its last value. valid_o=0 in all states other than READ and WRITE.
- req_i while ready_o=0 is ignored. No queueing.
- clear_i=1 in WAIT, READ, WRITE or DONE:
  - Next cycle is IDLE with ready_o=1; no done_o is generated.
  - Writes already performed stay in RAM.
  - A write beat coinciding with clear_i is not performed.
- clear_i=1 with req_i=1 in IDLE: clear wins and the request is dropped.
- Other inputs changing mid-transaction have no effect; all transaction parameters are latched at acceptance.
- Reset asserted mid-transaction: immediate return to reset values. A partially written block remains partially written.
- Beat counter width is log2(BLOCK_WORDS)+1. Wait counter width is clog2(WAIT_CYCLES+1).

Optional Feature:
- Macro EXT_MEM_BOUNDS_CHECK_EN.
- Defined:
  - Any accepted request whose word index ≥ DEPTH_WORDS sets err_o (sticky until reset).
  - Writes to such addresses are dropped.
  - Reads return 32'hDEADBEEF.
  - Handshake timing is unchanged.
- Undefined:
  - err_o is tied 0.
  - Address is taken modulo DEPTH_WORDS (upper bits ignored).

Decomposition:
- Shared package ext_mem_pkg:
  - State encoding localparams.
  - RW_WRITE=1 and RW_READ=0.
  - ERR_READ_PATTERN=32'hDEADBEEF.
  - Byte-to-word address helper function.
- One sub-module, ext_mem_ram_sp: single-port synchronous RAM with one-cycle read latency and write-first behaviour; infers block RAM.

Test Plan:
- Single write then read: write 32'hCAFE0001 to byte address 0x100, then read 0x100. With WAIT_CYCLES=3: valid_o at cycle 4, data_o=32'hCAFE0001, done_o at cycle 5, ready_o at cycle 6.
- Block write then block read:
  - Block write at 0x0000_0024 (aligns to word 8, byte 0x20) with data 0x10..0x17; valid_o for 8 consecutive cycles.
  - Block read at 0x20 returns 0x10..0x17 in order, done_o once.
- clear_i on the 3rd write beat of a block: words 0–1 written, word 2 not written, no done_o, ready_o=1 on the next cycle; subsequent reads confirm.
- req_i pulses during a busy transaction and simultaneously with clear_i in IDLE: both ignored; ready_o/done_o sequence matches a single transaction.
- Async reset asserted mid-READ: outputs return to reset values without a clock edge. A new read afterwards returns previously written data.
- With EXT_MEM_BOUNDS_CHECK_EN and DEPTH_WORDS=1024: read at byte 0x1000 returns 32'hDEADBEEF and err_o=1 stays high. Without the macro, the same read aliases to word 0.
